target_track_ctrl: RTL and testbench
====================================

TARGET_TRACK_CTRL -- requirements
Module: target_track_ctrl

Interface
REQ-001 SHALL have parameter SEED_XY, default {12'd640,12'd360}, giving the search centre used on reset and when the target is lost.
REQ-002 SHALL have parameter PROF_NUM, default 3'd4, giving the number of threshold profiles cycled during search (range 1-4).
REQ-003 SHALL use one clock and one reset: the clock is clk, and the reset is rst, synchronous and active-high.
REQ-004 Port list (name  direction  width  meaning), clock and reset first:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- per_frame_vsync  in  1  frame-valid from the video stream
- det_en  in  1  detector hit flag for the last frame
- det_left/det_right/det_top/det_down  in  12 each  detector box
- acq_frames  in  4  consecutive hits required to lock
- lost_frames  in  4  consecutive misses tolerated before search
- max_jump  in  12  per-axis centre-move limit
- search_xy  out  24  {x,y} window centre driven to the detector in_red input
- prof_sel  out  2  threshold-profile select
- state  out  2  FSM state
- track_valid  out  1  target locked
- target_xy  out  24  {x,y} locked centre

Function
REQ-005 SHALL register per_frame_vsync once; the rising-edge pulse vs_pos SHALL be high for exactly one cycle per frame.
REQ-006 SHALL assert the internal strobe eval exactly 2 cycles after vs_pos, and SHALL make every FSM decision only on eval.
REQ-007 SHALL compute the box centre as cx=(det_left+det_right)>>1 and cy=(det_top+det_down)>>1, using 13-bit sums so the results cannot wrap.
REQ-008 SHALL treat a frame as near only if |cx-target_x|<=max_jump and |cy-target_y|<=max_jump, using unsigned absolute difference.
REQ-009 SHALL define hit = det_en, and miss = !det_en.
REQ-010 SHALL implement the FSM states SEARCH=0, ACQ=1, TRACK=2, COAST=3.
REQ-011 SEARCH transitions on eval:
- On hit: set target_xy<={cx,cy}, hit_cnt<=1, and go to ACQ; if acq_frames<=1, go straight to TRACK instead.
- On miss: advance prof_sel modulo PROF_NUM.
REQ-012 ACQ transitions on eval:
- On hit and near: hit_cnt++ and target_xy<={cx,cy}; when hit_cnt+1==acq_frames, go to TRACK.
- On miss or not near: go to SEARCH, set hit_cnt<=0, and set search_xy<=SEED_XY.
REQ-013 TRACK transitions on eval:
- On hit and near: set target_xy and search_xy to {cx,cy}, and miss_cnt<=0.
- On miss or not near: set miss_cnt<=1 and go to COAST; target_xy and search_xy hold.
REQ-014 COAST transitions on eval:
- On hit and near: go to TRACK with the same updates as REQ-013.
- Otherwise: miss_cnt++; when miss_cnt+1>=lost_frames (or lost_frames==0), go to SEARCH, set search_xy<=SEED_XY, and clear hit_cnt and miss_cnt.
REQ-015 SHALL hold prof_sel constant in ACQ, TRACK and COAST, so the locked profile is kept.
REQ-016 SHALL drive track_valid=1 only in TRACK and COAST; it SHALL be registered and change in the cycle after eval.
REQ-017 In ACQ, search_xy SHALL follow target_xy, so the detector window re-centres on the candidate.
REQ-018 SHALL saturate hit_cnt and miss_cnt at 15 and never wrap.
REQ-019 Changes to acq_frames, lost_frames or max_jump SHALL take effect at the next eval.
REQ-020 If vs_pos occurs while an eval is pending, the pending eval SHALL still fire, and the new frame's eval SHALL follow at vs_pos+2.

Reset
REQ-021 While rst=1 at a clk edge, outputs SHALL be: state=SEARCH, search_xy=SEED_XY, target_xy=SEED_XY, prof_sel=0, track_valid=0.
REQ-022 While rst=1, hit_cnt, miss_cnt, the vsync register and the eval pipeline SHALL be 0.
REQ-023 A reset asserted mid-frame SHALL discard any pending eval; the first decision after reset SHALL follow the next vs_pos.

Verification
REQ-024 Search cycling: reset, then 5 frames with det_en=0 and PROF_NUM=4 -> prof_sel goes 1,2,3,0,1, state stays SEARCH, track_valid stays 0.
REQ-025 Lock-on: acq_frames=3, max_jump=20, boxes centred (400,300), (405,302), (410,305) -> ACQ, ACQ, then TRACK at the 3rd eval; track_valid=1; target_xy=search_xy={410,305}.
REQ-026 Jump reject: in ACQ with target (400,300), a box centred (450,300) and max_jump=20 -> SEARCH; search_xy={640,360}; prof_sel unchanged from its lock value.
REQ-027 Coast and loss: in TRACK with lost_frames=2, then miss, miss -> COAST (track_valid=1, target held), then SEARCH; track_valid falls 1 cycle after the 2nd eval.
REQ-028 Coast recovery: in COAST, a near hit at (412,306) -> TRACK; miss_cnt=0; target_xy={412,306}.
REQ-029 Mid-frame reset: assert rst 1 cycle after vs_pos -> no eval occurs; all outputs take their reset values; the next frame is evaluated normally.

Source files
------------

// File: rtl/target_track_ctrl.sv
// rtl/target_track_ctrl.sv - detector-driven target acquire/track/coast controller
// Frame edge strobes a 2-cycle eval pipeline; every FSM decision uses the detector box at eval.
module target_track_ctrl #(
  parameter logic [23:0] SEED_XY  = {12'd640, 12'd360},
  parameter logic [2:0]  PROF_NUM = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        det_en,
  input  logic [11:0] det_left,
  input  logic [11:0] det_right,
  input  logic [11:0] det_top,
  input  logic [11:0] det_down,
  input  logic [3:0]  acq_frames,
  input  logic [3:0]  lost_frames,
  input  logic [11:0] max_jump,
  output logic [23:0] search_xy,
  output logic [1:0]  prof_sel,
  output logic [1:0]  state,
  output logic        track_valid,
  output logic [23:0] target_xy
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ACQ    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_COAST  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nxt_state;
  logic        r_vs_d;
  logic [1:0]  r_ev;
  logic [23:0] r_search_xy;
  logic [23:0] r_target_xy;
  logic [1:0]  r_prof_sel;
  logic        r_track_valid;
  logic        w_track_valid_nxt;
  logic [3:0]  r_hit_cnt;
  logic [3:0]  r_miss_cnt;

  logic        w_vs_pos;
  logic        w_eval;
  logic [12:0] w_sum_x;
  logic [12:0] w_sum_y;
  logic [11:0] w_cx;
  logic [11:0] w_cy;
  logic [11:0] w_dx;
  logic [11:0] w_dy;
  logic        w_near;
  logic        w_good;
  logic        w_acq_done;
  logic        w_lost;
  logic [2:0]  w_prof_p1;
  logic [1:0]  w_prof_nxt;
  logic [3:0]  w_hit_inc;
  logic [3:0]  w_miss_inc;

  assign w_vs_pos = per_frame_vsync & ~r_vs_d;
  assign w_eval   = r_ev[1];

  // 13-bit sums keep the midpoint exact even for boxes at the far edge
  assign w_sum_x = {1'b0, det_left} + {1'b0, det_right};
  assign w_sum_y = {1'b0, det_top}  + {1'b0, det_down};
  assign w_cx    = 12'(w_sum_x >> 1);
  assign w_cy    = 12'(w_sum_y >> 1);
  assign w_dx    = (w_cx >= r_target_xy[23:12]) ? (w_cx - r_target_xy[23:12]) : (r_target_xy[23:12] - w_cx);
  assign w_dy    = (w_cy >= r_target_xy[11:0])  ? (w_cy - r_target_xy[11:0])  : (r_target_xy[11:0] - w_cy);
  assign w_near  = (w_dx <= max_jump) && (w_dy <= max_jump);
  assign w_good  = det_en && w_near;

  assign w_hit_inc  = (r_hit_cnt == 4'd15)  ? 4'd15 : r_hit_cnt + 4'd1;
  assign w_miss_inc = (r_miss_cnt == 4'd15) ? 4'd15 : r_miss_cnt + 4'd1;
  assign w_acq_done = ({1'b0, r_hit_cnt} + 5'd1) == {1'b0, acq_frames};
  assign w_lost     = (({1'b0, r_miss_cnt} + 5'd1) >= {1'b0, lost_frames}) || (lost_frames == 4'd0);
  assign w_prof_p1  = {1'b0, r_prof_sel} + 3'd1;
  assign w_prof_nxt = (w_prof_p1 >= PROF_NUM) ? 2'd0 : w_prof_p1[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    if (w_eval) begin
      case (r_state)
        ST_SEARCH: if (det_en) w_nxt_state = (acq_frames <= 4'd1) ? ST_TRACK : ST_ACQ;
        ST_ACQ:    if (!w_good) w_nxt_state = ST_SEARCH;
                   else if (w_acq_done) w_nxt_state = ST_TRACK;
        ST_TRACK:  if (!w_good) w_nxt_state = ST_COAST;
        ST_COAST:  if (w_good) w_nxt_state = ST_TRACK;
                   else if (w_lost) w_nxt_state = ST_SEARCH;
        default:   w_nxt_state = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    w_track_valid_nxt = (w_nxt_state == ST_TRACK) || (w_nxt_state == ST_COAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d        <= 1'b0;
      r_ev          <= 2'b00;
      r_search_xy   <= SEED_XY;
      r_target_xy   <= SEED_XY;
      r_prof_sel    <= 2'd0;
      r_track_valid <= 1'b0;
      r_hit_cnt     <= 4'd0;
      r_miss_cnt    <= 4'd0;
    end else begin
      r_vs_d        <= per_frame_vsync;
      r_ev          <= {r_ev[0], w_vs_pos};
      r_track_valid <= w_track_valid_nxt;
      if (w_eval) begin
        case (r_state)
          ST_SEARCH: begin
            if (det_en) begin
              r_target_xy <= {w_cx, w_cy};
              r_search_xy <= {w_cx, w_cy};
              r_hit_cnt   <= 4'd1;
            end else begin
              r_prof_sel  <= w_prof_nxt;
            end
          end
          ST_ACQ: begin
            if (w_good) begin
              r_hit_cnt   <= w_hit_inc;
              r_target_xy <= {w_cx, w_cy};
              r_search_xy <= {w_cx, w_cy};
            end else begin
              r_hit_cnt   <= 4'd0;
              r_search_xy <= SEED_XY;
            end
          end
          default: begin
            if (w_good) begin
              r_target_xy <= {w_cx, w_cy};
              r_search_xy <= {w_cx, w_cy};
              r_miss_cnt  <= 4'd0;
            end else if (r_state == ST_TRACK) begin
              r_miss_cnt  <= 4'd1;
            end else if (w_lost) begin
              r_search_xy <= SEED_XY;
              r_hit_cnt   <= 4'd0;
              r_miss_cnt  <= 4'd0;
            end else begin
              r_miss_cnt  <= w_miss_inc;
            end
          end
        endcase
      end
    end
  end

  assign search_xy   = r_search_xy;
  assign target_xy   = r_target_xy;
  assign prof_sel    = r_prof_sel;
  assign state       = r_state;
  assign track_valid = r_track_valid;

endmodule

// File: tb/tb_target_track_ctrl.sv
// tb/tb_target_track_ctrl.sv - table-driven frame vectors plus timing/reset corner sequences
// Each vector is one frame; outputs are checked once the frame's eval has been taken.
module tb_target_track_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        per_frame_vsync;
  logic        det_en;
  logic [11:0] det_left, det_right, det_top, det_down;
  logic [3:0]  acq_frames, lost_frames;
  logic [11:0] max_jump;
  logic [23:0] search_xy;
  logic [1:0]  prof_sel;
  logic [1:0]  state;
  logic        track_valid;
  logic [23:0] target_xy;

  int total = 0;
  int bad   = 0;

  localparam logic [23:0] SEED = {12'd640, 12'd360};

  typedef struct {
    logic        en;
    logic [11:0] l, r, t, d;
    logic [3:0]  acq, lost;
    logic [11:0] jmp;
    logic [1:0]  e_state;
    logic        e_tv;
    logic [23:0] e_tgt;
    logic [23:0] e_srch;
    logic [1:0]  e_prof;
  } vec_t;

  vec_t vecs[$];

  target_track_ctrl dut (
    .clk(clk), .rst(rst), .per_frame_vsync(per_frame_vsync), .det_en(det_en),
    .det_left(det_left), .det_right(det_right), .det_top(det_top), .det_down(det_down),
    .acq_frames(acq_frames), .lost_frames(lost_frames), .max_jump(max_jump),
    .search_xy(search_xy), .prof_sel(prof_sel), .state(state),
    .track_valid(track_valid), .target_xy(target_xy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] xy(input int x, input int y);
    logic [11:0] xx, yy;
    xx = 12'(x);
    yy = 12'(y);
    return {xx, yy};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic add(input logic en, input int l, input int r, input int t, input int d,
                     input int acq, input int lost, input int jmp,
                     input int st, input logic tv, input logic [23:0] tgt,
                     input logic [23:0] srch, input int prof);
    vec_t v;
    v.en = en; v.l = 12'(l); v.r = 12'(r); v.t = 12'(t); v.d = 12'(d);
    v.acq = 4'(acq); v.lost = 4'(lost); v.jmp = 12'(jmp);
    v.e_state = 2'(st); v.e_tv = tv; v.e_tgt = tgt; v.e_srch = srch; v.e_prof = 2'(prof);
    vecs.push_back(v);
  endtask

  task automatic set_in(input logic en, input int l, input int r, input int t, input int d,
                        input int acq, input int lost, input int jmp);
    det_en = en; det_left = 12'(l); det_right = 12'(r); det_top = 12'(t); det_down = 12'(d);
    acq_frames = 4'(acq); lost_frames = 4'(lost); max_jump = 12'(jmp);
  endtask

  // called at a negedge; returns at a negedge well after the frame's eval
  task automatic run_frame();
    per_frame_vsync = 1'b1;
    repeat (6) @(negedge clk);
    per_frame_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic tv,
                           input logic [23:0] tgt, input logic [23:0] srch, input logic [1:0] prof);
    check({tag, ".state"},       {22'd0, state},       {22'd0, st});
    check({tag, ".track_valid"}, {23'd0, track_valid}, {23'd0, tv});
    check({tag, ".target_xy"},   target_xy,            tgt);
    check({tag, ".search_xy"},   search_xy,            srch);
    check({tag, ".prof_sel"},    {22'd0, prof_sel},    {22'd0, prof});
  endtask

  initial begin
    rst = 1'b1;
    per_frame_vsync = 1'b0;
    set_in(1'b0, 0, 0, 0, 0, 3, 2, 20);

    // search cycling
    add(0, 0,0,0,0, 3,2,20, 0,0, SEED, SEED, 1);
    add(0, 0,0,0,0, 3,2,20, 0,0, SEED, SEED, 2);
    add(0, 0,0,0,0, 3,2,20, 0,0, SEED, SEED, 3);
    add(0, 0,0,0,0, 3,2,20, 0,0, SEED, SEED, 0);
    add(0, 0,0,0,0, 3,2,20, 0,0, SEED, SEED, 1);
    // lock-on
    add(1, 390,410,290,310, 3,2,20, 1,0, xy(400,300), xy(400,300), 1);
    add(1, 395,415,292,312, 3,2,20, 1,0, xy(405,302), xy(405,302), 1);
    add(1, 400,420,295,315, 3,2,20, 2,1, xy(410,305), xy(410,305), 1);
    // coast, recovery, loss
    add(0, 0,0,0,0,         3,2,20, 3,1, xy(410,305), xy(410,305), 1);
    add(1, 402,422,296,316, 3,2,20, 2,1, xy(412,306), xy(412,306), 1);
    add(0, 0,0,0,0,         3,2,20, 3,1, xy(412,306), xy(412,306), 1);
    add(0, 0,0,0,0,         3,2,20, 0,0, xy(412,306), SEED, 1);
    // jump reject in ACQ
    add(1, 390,410,290,310, 3,2,20, 1,0, xy(400,300), xy(400,300), 1);
    add(1, 440,460,290,310, 3,2,20, 0,0, xy(400,300), SEED, 1);
    add(0, 0,0,0,0,         3,2,20, 0,0, xy(400,300), SEED, 2);
    // acq_frames=1 locks at once; extreme box needs 13-bit sums
    add(1, 90,110,40,60,         1,2,20,   2,1, xy(100,50),   xy(100,50),   2);
    add(1, 4095,4095,4094,4095,  1,2,4095, 2,1, xy(4095,4094), xy(4095,4094), 2);
    // lost_frames=0 drops on the first coasting miss
    add(0, 0,0,0,0, 1,0,20, 3,1, xy(4095,4094), xy(4095,4094), 2);
    add(0, 0,0,0,0, 1,0,20, 0,0, xy(4095,4094), SEED, 2);

    repeat (3) @(negedge clk);
    check_all("reset", 2'd0, 1'b0, SEED, SEED, 2'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].en, vecs[i].l, vecs[i].r, vecs[i].t, vecs[i].d,
             vecs[i].acq, vecs[i].lost, vecs[i].jmp);
      run_frame();
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_tv,
                vecs[i].e_tgt, vecs[i].e_srch, vecs[i].e_prof);
    end

    // track_valid falls exactly one cycle after the losing eval
    set_in(1'b1, 390, 410, 290, 310, 1, 2, 20);
    run_frame();
    check("tvt.lock", {22'd0, state}, 24'd2);
    set_in(1'b0, 0, 0, 0, 0, 1, 2, 20);
    run_frame();
    check("tvt.coast", {22'd0, state}, 24'd3);
    per_frame_vsync = 1'b1;
    @(negedge clk);
    check("tvt.p0_tv", {23'd0, track_valid}, 24'd1);
    @(negedge clk);
    check("tvt.eval_tv", {23'd0, track_valid}, 24'd1);
    check("tvt.eval_state", {22'd0, state}, 24'd3);
    @(negedge clk);
    check("tvt.after_tv", {23'd0, track_valid}, 24'd0);
    check("tvt.after_state", {22'd0, state}, 24'd0);
    repeat (3) @(negedge clk);
    per_frame_vsync = 1'b0;
    repeat (4) @(negedge clk);

    // a second frame edge while an eval is pending: both evals fire (prof 2 -> 3 -> 0)
    check("pend.prof_before", {22'd0, prof_sel}, 24'd2);
    per_frame_vsync = 1'b1;
    @(negedge clk);
    per_frame_vsync = 1'b0;
    @(negedge clk);
    per_frame_vsync = 1'b1;
    @(negedge clk);
    per_frame_vsync = 1'b0;
    repeat (6) @(negedge clk);
    check("pend.prof_after", {22'd0, prof_sel}, 24'd0);
    check("pend.state", {22'd0, state}, 24'd0);

    // mid-frame reset discards the pending eval
    set_in(1'b0, 0, 0, 0, 0, 1, 2, 20);
    run_frame();
    set_in(1'b1, 390, 410, 290, 310, 1, 2, 20);
    run_frame();
    check_all("mr.pre", 2'd2, 1'b1, xy(400,300), xy(400,300), 2'd1);
    set_in(1'b0, 0, 0, 0, 0, 1, 2, 20);
    per_frame_vsync = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    per_frame_vsync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_all("mr.post", 2'd0, 1'b0, SEED, SEED, 2'd0);
    set_in(1'b1, 390, 410, 290, 310, 1, 2, 20);
    run_frame();
    check_all("mr.next", 2'd2, 1'b1, xy(400,300), xy(400,300), 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
